uart_wb_bridge: RTL and testbench

//  Debug bus master sitting directly upstream of the uart block on its register port: polls uart

---
 rtl/uart_wb_bridge_pkg.sv | 33 +++
 rtl/uart_reg_master.sv | 83 ++++++++
 rtl/uart_wb_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_uart_wb_bridge.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_wb_bridge_pkg.sv
// Shared constants for the uart debug bridge: protocol opcodes, reply
// bytes, uart register indices, status bit positions and FSM encodings.
package uart_wb_bridge_pkg;

    // Command opcodes (first byte of every command)
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    // Single-byte replies
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_BAD = 8'h3F;
    localparam logic [7:0] RSP_ERR = 8'h45;

    // uart register select values
    localparam logic [1:0] UREG_DATA   = 2'd0;
    localparam logic [1:0] UREG_STATUS = 2'd1;

    // uart status word bit positions
    localparam int ST_REC_EMPTY = 0;
    localparam int ST_SEND_FULL = 4;

    // Bridge FSM encodings
    localparam logic [2:0] S_RX_POLL = 3'd0;
    localparam logic [2:0] S_RX_POP  = 3'd1;
    localparam logic [2:0] S_BUS     = 3'd2;
    localparam logic [2:0] S_TX_POLL = 3'd3;
    localparam logic [2:0] S_TX_PUSH = 3'd4;

    function automatic logic is_cmd_op(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/uart_reg_master.sv
// Single-access master on the uart register port.
// Ports: req/we/adr/wdata request in; done pulse + rdata out;
//        u_* wishbone-style strobe/ack port towards the uart.
module uart_reg_master (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  adr_i,
    input  logic [7:0]  wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        u_stb_o,
    output logic        u_we_o,
    output logic [1:0]  u_adr_o,
    output logic [3:0]  u_sel_o,
    output logic [31:0] u_dat_o,
    input  logic [31:0] u_dat_i,
    input  logic        u_ack_i
);

    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic [1:0]  adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [7:0]  wdat_q, wdat_d;
    logic [31:0] rdata_q, rdata_d;

    // A new access may only start when neither busy nor in the done
    // cycle; the done cycle doubles as the mandatory strobe-low gap.
    always_comb begin
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        if (stb_q) begin
            if (u_ack_i) begin
                stb_d   = 1'b0;
                done_d  = 1'b1;
                rdata_d = u_dat_i;
            end
        end else if (req_i && !done_q) begin
            stb_d  = 1'b1;
            we_d   = we_i;
            adr_d  = adr_i;
            sel_d  = we_i ? 4'b0001 : 4'b1111;
            wdat_d = we_i ? wdata_i : 8'h00;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            adr_q   <= 2'd0;
            sel_q   <= 4'd0;
            wdat_q  <= 8'd0;
            rdata_q <= 32'd0;
        end else begin
            stb_q   <= stb_d;
            we_q    <= we_d;
            done_q  <= done_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
        end
    end

    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign u_stb_o = stb_q;
    assign u_we_o  = we_q;
    assign u_adr_o = adr_q;
    assign u_sel_o = sel_q;
    assign u_dat_o = {24'h0, wdat_q};

endmodule

// File: rtl/uart_wb_bridge.sv
// uart-driven debug bus master: decodes 'W'/'R' byte commands from the
// uart rx FIFO, performs one 32-bit system bus access, replies via uart.
// Ports: clk_i/rst_i; u_* uart register port; m_* system bus port.
// Config: UART_WB_BRIDGE_TIMEOUT_EN adds a BUS_TIMEOUT ack watchdog.
module uart_wb_bridge
    import uart_wb_bridge_pkg::*;
#(
    parameter logic [15:0] BUS_TIMEOUT = 16'd1023
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        u_stb_o,
    output logic        u_we_o,
    output logic [1:0]  u_adr_o,
    output logic [3:0]  u_sel_o,
    output logic [31:0] u_dat_o,
    input  logic [31:0] u_dat_i,
    input  logic        u_ack_i,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [31:0] m_adr_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i
);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  op_q, op_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rsp_q, rsp_d;
    logic [2:0]  rsp_cnt_q, rsp_cnt_d;
    logic        m_stb_q, m_stb_d;
    logic        m_we_q, m_we_d;

    logic        ur_req;
    logic        ur_we;
    logic [1:0]  ur_adr;
    logic        ur_done;
    logic [31:0] ur_rdata;
    logic [7:0]  rx_byte;
    logic        unused_rdata;

    // Every state except BUS talks to the uart
    assign ur_req = (state_q != S_BUS);
    assign ur_we  = (state_q == S_TX_PUSH);
    assign ur_adr = (state_q == S_RX_POP || state_q == S_TX_PUSH)
                  ? UREG_DATA : UREG_STATUS;

    assign rx_byte      = ur_rdata[7:0];
    assign unused_rdata = ^ur_rdata[31:8];

    uart_reg_master u_master (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (ur_req),
        .we_i    (ur_we),
        .adr_i   (ur_adr),
        .wdata_i (rsp_q[31:24]),
        .done_o  (ur_done),
        .rdata_o (ur_rdata),
        .u_stb_o (u_stb_o),
        .u_we_o  (u_we_o),
        .u_adr_o (u_adr_o),
        .u_sel_o (u_sel_o),
        .u_dat_o (u_dat_o),
        .u_dat_i (u_dat_i),
        .u_ack_i (u_ack_i)
    );

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    logic [15:0] timer_q, timer_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^BUS_TIMEOUT;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        rsp_d     = rsp_q;
        rsp_cnt_d = rsp_cnt_q;
        m_stb_d   = m_stb_q;
        m_we_d    = m_we_q;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
        timer_d   = 16'd0;
`endif
        unique case (state_q)
            S_RX_POLL: begin
                if (ur_done) begin
                    state_d = ur_rdata[ST_REC_EMPTY] ? S_RX_POLL : S_RX_POP;
                end
            end
            S_RX_POP: begin
                if (ur_done) begin
                    state_d = S_RX_POLL;
                    if (cnt_q == 4'd0) begin
                        op_d = rx_byte;
                        if (is_cmd_op(rx_byte)) begin
                            cnt_d = 4'd1;
                        end else begin
                            rsp_d     = {RSP_BAD, 24'h0};
                            rsp_cnt_d = 3'd1;
                            state_d   = S_TX_POLL;
                        end
                    end else if (cnt_q <= 4'd4) begin
                        adr_d = {adr_q[23:0], rx_byte};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd4 && op_q == OP_READ) begin
                            cnt_d   = 4'd0;
                            m_stb_d = 1'b1;
                            m_we_d  = 1'b0;
                            state_d = S_BUS;
                        end
                    end else begin
                        wdat_d = {wdat_q[23:0], rx_byte};
                        cnt_d  = cnt_q + 4'd1;
                        if (cnt_q == 4'd8) begin
                            cnt_d   = 4'd0;
                            m_stb_d = 1'b1;
                            m_we_d  = 1'b1;
                            state_d = S_BUS;
                        end
                    end
                end
            end
            S_BUS: begin
                if (m_ack_i) begin
                    m_stb_d = 1'b0;
                    m_we_d  = 1'b0;
                    state_d = S_TX_POLL;
                    if (m_we_q) begin
                        rsp_d     = {RSP_OK, 24'h0};
                        rsp_cnt_d = 3'd1;
                    end else begin
                        rsp_d     = m_dat_i;
                        rsp_cnt_d = 3'd4;
                    end
                end
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
                else if (timer_q == BUS_TIMEOUT - 16'd1) begin
                    m_stb_d   = 1'b0;
                    m_we_d    = 1'b0;
                    rsp_d     = {RSP_ERR, 24'h0};
                    rsp_cnt_d = 3'd1;
                    state_d   = S_TX_POLL;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
`endif
            end
            S_TX_POLL: begin
                if (ur_done) begin
                    state_d = ur_rdata[ST_SEND_FULL] ? S_TX_POLL : S_TX_PUSH;
                end
            end
            S_TX_PUSH: begin
                if (ur_done) begin
                    rsp_d     = {rsp_q[23:0], 8'h00};
                    rsp_cnt_d = rsp_cnt_q - 3'd1;
                    state_d   = (rsp_cnt_q == 3'd1) ? S_RX_POLL : S_TX_POLL;
                end
            end
            default: state_d = S_RX_POLL;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_RX_POLL;
            cnt_q     <= 4'd0;
            op_q      <= 8'd0;
            adr_q     <= 32'd0;
            wdat_q    <= 32'd0;
            rsp_q     <= 32'd0;
            rsp_cnt_q <= 3'd0;
            m_stb_q   <= 1'b0;
            m_we_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            rsp_q     <= rsp_d;
            rsp_cnt_q <= rsp_cnt_d;
            m_stb_q   <= m_stb_d;
            m_we_q    <= m_we_d;
        end
    end

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q <= 16'd0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign m_stb_o = m_stb_q;
    assign m_we_o  = m_we_q;
    assign m_adr_o = adr_q;
    assign m_sel_o = {4{m_stb_q}};
    assign m_dat_o = wdat_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Scoreboard bench for uart_wb_bridge: uart and bus responder models,
// command generator with reference model, decoupled output monitor.
module tb_uart_wb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        u_stb_o, u_we_o;
    logic [1:0]  u_adr_o;
    logic [3:0]  u_sel_o;
    logic [31:0] u_dat_o, u_dat_i;
    logic        u_ack_i;
    logic        m_stb_o, m_we_o;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_ack_i;

    uart_wb_bridge #(.BUS_TIMEOUT(16'd16)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .u_stb_o (u_stb_o),
        .u_we_o  (u_we_o),
        .u_adr_o (u_adr_o),
        .u_sel_o (u_sel_o),
        .u_dat_o (u_dat_o),
        .u_dat_i (u_dat_i),
        .u_ack_i (u_ack_i),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_adr_o (m_adr_o),
        .m_sel_o (m_sel_o),
        .m_dat_o (m_dat_o),
        .m_dat_i (m_dat_i),
        .m_ack_i (m_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  exp_tx[$];
    bus_t        exp_bus[$];
    logic [31:0] bus_rd[$];

    logic send_full = 1'b0;
    logic last_full = 1'b0;
    logic rand_full = 1'b0;
    logic bus_noack = 1'b0;
    int   uart_wr_cnt = 0;
    int   u_lat = 0;
    int   m_lat = 0;
    int   rx_sz;
    bus_t e;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- uart register port model ----------------
    initial begin
        u_ack_i = 1'b0;
        u_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (u_ack_i) begin
                u_ack_i = 1'b0;
                u_dat_i = $urandom();
            end else if (u_stb_o) begin
                if (u_lat > 0) begin
                    u_lat--;
                end else begin
                    u_ack_i = 1'b1;
                    u_lat   = $urandom_range(0, 2);
                    if (u_we_o) begin
                        u_dat_i = $urandom();
                    end else if (u_adr_o == 2'd1) begin
                        rx_sz = (rxq.size() > 255) ? 255 : rxq.size();
                        last_full = send_full;
                        u_dat_i = {uart_wr_cnt[7:0], rx_sz[7:0], 11'h0,
                                   send_full, 3'b0, (rxq.size() == 0)};
                    end else if (rxq.size() != 0) begin
                        u_dat_i = {24'h0, rxq.pop_front()};
                    end else begin
                        u_dat_i = 32'h0;
                    end
                end
            end
        end
    end

    // ---------------- system bus slave model ----------------
    initial begin
        m_ack_i = 1'b0;
        m_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (m_ack_i) begin
                m_ack_i = 1'b0;
                m_dat_i = $urandom();
            end else if (m_stb_o && !bus_noack) begin
                if (m_lat > 0) begin
                    m_lat--;
                end else begin
                    m_ack_i = 1'b1;
                    m_lat   = $urandom_range(0, 3);
                    if (!m_we_o) begin
                        m_dat_i = (bus_rd.size() != 0) ? bus_rd.pop_front()
                                                       : 32'h0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_full) send_full = ($urandom_range(0, 3) == 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (u_stb_o && u_adr_o == 2'd2) begin
                n_cmp++;
                n_bad++;
                $display("FAIL uart_baud_access: got adr 2 want 0 or 1");
            end
            if (u_stb_o && u_ack_i && u_we_o) begin
                uart_wr_cnt++;
                check("uart_wr_adr", u_adr_o, 32'd0);
                check("uart_wr_sel", u_sel_o, 32'd1);
                check("wr_after_full", last_full, 32'd0);
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL reply_extra: got byte %h want none",
                             u_dat_o);
                end else begin
                    check("reply_byte", u_dat_o, {24'h0, exp_tx.pop_front()});
                end
            end
            if (m_stb_o && m_ack_i) begin
                if (exp_bus.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL bus_extra: got access adr %h want none",
                             m_adr_o);
                end else begin
                    e = exp_bus.pop_front();
                    check("bus_we", m_we_o, e.we);
                    check("bus_adr", m_adr_o, e.adr);
                    check("bus_sel", m_sel_o, 32'hF);
                    if (e.we) check("bus_wdat", m_dat_o, e.dat);
                end
            end
        end
    end

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    int stb_run = 0;
    int last_run = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (m_stb_o) begin
                stb_run++;
            end else if (stb_run != 0) begin
                last_run = stb_run;
                stb_run  = 0;
            end
        end
    end
`endif

    // ---------------- reference model / stimulus ----------------
    task automatic feed32(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) rxq.push_back(w[8*i +: 8]);
    endtask

    task automatic cmd_write(input logic [31:0] a, input logic [31:0] d);
        rxq.push_back(8'h57);
        feed32(a);
        feed32(d);
        exp_bus.push_back('{we: 1'b1, adr: a, dat: d});
        exp_tx.push_back(8'h4B);
    endtask

    task automatic cmd_read(input logic [31:0] a, input logic [31:0] rd);
        rxq.push_back(8'h52);
        feed32(a);
        exp_bus.push_back('{we: 1'b0, adr: a, dat: 32'h0});
        bus_rd.push_back(rd);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
    endtask

    task automatic cmd_junk(input logic [7:0] op);
        rxq.push_back(op);
        exp_tx.push_back(8'h3F);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while ((rxq.size() + exp_tx.size() + exp_bus.size()) != 0
               && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if ((rxq.size() + exp_tx.size() + exp_bus.size()) != 0) begin
            n_bad++;
            $display("FAIL %s: got %0d replies %0d bus ops pending want 0",
                     name, exp_tx.size(), exp_bus.size());
        end
    endtask

    initial begin
        int k;
        int w0;
        logic [7:0] op;

        rst = 1'b1;
        #1;
        check("rst_u_stb", u_stb_o, 32'd0);
        check("rst_u_we", u_we_o, 32'd0);
        check("rst_u_adr", u_adr_o, 32'd0);
        check("rst_u_sel", u_sel_o, 32'd0);
        check("rst_u_dat", u_dat_o, 32'd0);
        check("rst_m_stb", m_stb_o, 32'd0);
        check("rst_m_we", m_we_o, 32'd0);
        check("rst_m_adr", m_adr_o, 32'd0);
        check("rst_m_sel", m_sel_o, 32'd0);
        check("rst_m_dat", m_dat_o, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        cmd_write(32'h0000_1000, 32'hDEAD_BEEF);
        wait_drain("t1_write", 2000);

        cmd_read(32'h0000_1004, 32'h1234_5678);
        wait_drain("t2_read", 2000);

        cmd_junk(8'h00);
        cmd_read(32'h8000_0003, 32'hA5C3_0F1E);
        wait_drain("t3_junk", 2000);

        // reply held back by a full send FIFO
        send_full = 1'b1;
        cmd_read(32'h0000_2000, 32'hCAFE_F00D);
        k = 0;
        while (exp_bus.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("t4_bus_done", exp_bus.size(), 32'd0);
        w0 = uart_wr_cnt;
        repeat (200) @(negedge clk);
        check("t4_full_writes", uart_wr_cnt - w0, 32'd0);
        check("t4_pending", exp_tx.size(), 32'd4);
        send_full = 1'b0;
        wait_drain("t4_release", 2000);

        // reset in the middle of a write command
        rxq.push_back(8'h57);
        rxq.push_back(8'h00);
        rxq.push_back(8'h00);
        k = 0;
        while (rxq.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        k = 0;
        while (!u_stb_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t6_stb_before", u_stb_o, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_u_stb", u_stb_o, 32'd0);
        check("t6_m_stb", m_stb_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cmd_read(32'h0000_0010, 32'h0BAD_CAFE);
        wait_drain("t6_after_rst", 2000);

        // randomized back-to-back commands with a flapping send FIFO
        rand_full = 1'b1;
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 9);
            if (k < 4) begin
                cmd_write($urandom(), $urandom());
            end else if (k < 8) begin
                cmd_read($urandom(), $urandom());
            end else begin
                op = 8'($urandom_range(0, 255));
                if (op == 8'h57 || op == 8'h52) op = 8'hFF;
                cmd_junk(op);
            end
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 60)) @(negedge clk);
            end
        end
        wait_drain("random", 30000);
        rand_full = 1'b0;
        send_full = 1'b0;

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
        bus_noack = 1'b1;
        rxq.push_back(8'h52);
        feed32(32'h0000_3000);
        exp_tx.push_back(8'h45);
        wait_drain("t5_timeout", 2000);
        check("t5_stb_width", last_run, 32'd16);
        bus_noack = 1'b0;
        cmd_read(32'h0000_3004, 32'h5555_AAAA);
        wait_drain("t5_recover", 2000);
`endif

        check("end_bus_rd_left", bus_rd.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
